pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_fetch_ctrl_if.sv | 16 +
 rtl/pc_target_sel.sv | 37 +++
 rtl/pc_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch controller.
// Holds the FSM state encoding, the default reset PC and the PC width.
package pc_pkg;

  localparam int unsigned     PC_W             = 32;
  localparam logic [PC_W-1:0] PC_RESET_DEFAULT = 32'h0000_0000;

  // BOOT  : one idle cycle after reset, no fetch request.
  // FETCH : normal sequential fetching.
  // DRAIN : a redirect arrived while a request was in flight; wait for
  //         that response and throw it away.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bundle.
//   imem_req  : fetch request from the controller
//   imem_addr : fetch address from the controller
//   imem_ack  : memory accepted and returned the current request
// master = fetch controller, slave = instruction memory.
interface pc_fetch_ctrl_if;
  import pc_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);

endinterface

// File: rtl/pc_target_sel.sv
// Redirect target selection and word alignment (purely combinational).
//   pc_j/pc_b/pc_r           : jump, branch and register-jump targets
//   jump/branch_taken/jump_reg : redirect requests
//   target   : selected target with bits [1:0] cleared
//   redirect : any redirect request is active
//   misalign : raw bits [1:0] of the selected target were nonzero
module pc_target_sel
  import pc_pkg::*;
(
  input  logic [PC_W-1:0] pc_j,
  input  logic [PC_W-1:0] pc_b,
  input  logic [PC_W-1:0] pc_r,
  input  logic            jump,
  input  logic            branch_taken,
  input  logic            jump_reg,
  output logic [PC_W-1:0] target,
  output logic            redirect,
  output logic            misalign
);

  logic [PC_W-1:0] raw;

  // Priority: jump_reg, then jump, then branch_taken.
  always_comb begin
    raw = pc_b;
    if (jump_reg) begin
      raw = pc_r;
    end else if (jump) begin
      raw = pc_j;
    end
  end

  assign redirect = jump_reg | jump | branch_taken;
  assign target   = {raw[PC_W-1:2], 2'b00};
  assign misalign = redirect & (raw[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter and instruction-fetch controller.
//   clk, rst          : clock and asynchronous active-high reset
//   pc_j/pc_b/pc_r    : redirect targets
//   jump/branch_taken/jump_reg : redirect requests
//   stall             : pipeline hazard hold
//   imem              : instruction-memory request/ack bundle (master side)
//   pc, pc_plus4      : registered fetch PC and its sequential successor
//   instr_valid       : the instruction returned this cycle is to be used
//   addr_err          : a misaligned redirect target is being taken
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc_j,
  input  logic [PC_W-1:0]   pc_b,
  input  logic [PC_W-1:0]   pc_r,
  input  logic              jump,
  input  logic              branch_taken,
  input  logic              jump_reg,
  input  logic              stall,
  pc_fetch_ctrl_if.master   imem,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus4,
  output logic              instr_valid,
  output logic              addr_err
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            outst_q, outst_d;
  logic [PC_W-1:0] drain_addr_q, drain_addr_d;

  logic [PC_W-1:0] target;
  logic            redirect;
  logic            misalign;
  logic            req;
  logic            ack;

  pc_target_sel u_target_sel (
    .pc_j         (pc_j),
    .pc_b         (pc_b),
    .pc_r         (pc_r),
    .jump         (jump),
    .branch_taken (branch_taken),
    .jump_reg     (jump_reg),
    .target       (target),
    .redirect     (redirect),
    .misalign     (misalign)
  );

  assign ack      = imem.imem_ack;
  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    outst_d        = 1'b0;
    drain_addr_d   = drain_addr_q;
    req            = 1'b0;
    imem.imem_addr = pc_q;
    instr_valid    = 1'b0;
    addr_err       = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        // A request left unacknowledged last cycle must be held even
        // if the pipeline has since stalled.
        req      = ~stall | outst_q;
        addr_err = misalign;
        if (redirect) begin
          pc_d = target;
          if (req && !ack) begin
            // Remember the in-flight address so it can be held while
            // the stale response is drained.
            drain_addr_d = pc_q;
            state_d      = ST_DRAIN;
          end
        end else begin
          outst_d = req & ~ack;
          if (req && ack && !stall) begin
            instr_valid = 1'b1;
            pc_d        = pc_plus4;
          end
        end
      end

      ST_DRAIN: begin
        req            = 1'b1;
        imem.imem_addr = drain_addr_q;
        addr_err       = misalign;
        // Later redirects overwrite the pending target.
        if (redirect) begin
          pc_d = target;
        end
        if (ack) begin
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    imem.imem_req = req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      outst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
    end
  end

  // Only read in DRAIN, which is always entered through a capture.
  always_ff @(posedge clk) begin
    drain_addr_q <= drain_addr_d;
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;
  import pc_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     pc_j, pc_b, pc_r;
  logic            jump, branch_taken, jump_reg, stall;
  logic [31:0]     pc, pc_plus4;
  logic            instr_valid, addr_err;

  int total  = 0;
  int passed = 0;

  pc_fetch_ctrl_if imem_if ();

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_j         (pc_j),
    .pc_b         (pc_b),
    .pc_r         (pc_r),
    .jump         (jump),
    .branch_taken (branch_taken),
    .jump_reg     (jump_reg),
    .stall        (stall),
    .imem         (imem_if),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_redirect();
    jump = 1'b0; branch_taken = 1'b0; jump_reg = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; clr_redirect();
    pc_j = '0; pc_b = '0; pc_r = '0;
    imem_if.imem_ack = 1'b1;
    jump = 1'b1; pc_j = 32'h0000_0103;
    tick(); tick();
    #1;
    // Reset: outputs held quiet even with ack and a misaligned jump.
    chk32("rst_pc", pc, 32'h0);
    chk1("rst_req", imem_if.imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_adderr", addr_err, 1'b0);

    tick();
    rst = 1'b0; clr_redirect();
    #1;
    chk1("boot_req", imem_if.imem_req, 1'b0);
    chk1("boot_valid", instr_valid, 1'b0);

    tick(); #1;
    chk32("seq_addr0", imem_if.imem_addr, 32'h0);
    chk1("seq_valid0", instr_valid, 1'b1);
    chk32("seq_plus4", pc_plus4, 32'h4);
    tick(); #1;
    chk32("seq_addr4", imem_if.imem_addr, 32'h4);
    chk1("seq_valid4", instr_valid, 1'b1);
    tick(); #1;
    chk32("seq_addr8", imem_if.imem_addr, 32'h8);
    chk1("seq_valid8", instr_valid, 1'b1);

    // Jump beats branch, ack in same cycle.
    tick();
    jump = 1'b1; pc_j = 32'h0040_0100; branch_taken = 1'b1; pc_b = 32'h0000_0200;
    #1;
    chk32("jb_addr", imem_if.imem_addr, 32'hC);
    chk1("jb_valid", instr_valid, 1'b0);
    chk1("jb_adderr", addr_err, 1'b0);
    tick();
    clr_redirect();
    #1;
    chk32("jb_target", imem_if.imem_addr, 32'h0040_0100);
    chk1("jb_valid_next", instr_valid, 1'b1);

    // Move to 0x10 for the drain case.
    tick();
    jump = 1'b1; pc_j = 32'h10;
    tick();
    clr_redirect();
    imem_if.imem_ack = 1'b0; branch_taken = 1'b1; pc_b = 32'h80;
    #1;
    chk32("dr_addr0", imem_if.imem_addr, 32'h10);
    chk1("dr_valid0", instr_valid, 1'b0);
    tick();
    clr_redirect();
    #1;
    chk32("dr_pc", pc, 32'h80);
    chk1("dr_req1", imem_if.imem_req, 1'b1);
    chk32("dr_addr1", imem_if.imem_addr, 32'h10);
    tick(); #1;
    chk32("dr_addr2", imem_if.imem_addr, 32'h10);
    tick();
    imem_if.imem_ack = 1'b1;
    #1;
    chk32("dr_addr3", imem_if.imem_addr, 32'h10);
    chk1("dr_ack_valid", instr_valid, 1'b0);
    tick(); #1;
    chk32("dr_next_addr", imem_if.imem_addr, 32'h80);
    chk1("dr_next_valid", instr_valid, 1'b1);

    // Last redirect in DRAIN wins (now at 0x84).
    tick();
    imem_if.imem_ack = 1'b0; jump = 1'b1; pc_j = 32'h300;
    tick();
    clr_redirect(); branch_taken = 1'b1; pc_b = 32'h400;
    #1;
    chk32("lw_hold", imem_if.imem_addr, 32'h84);
    tick();
    clr_redirect(); imem_if.imem_ack = 1'b1;
    #1;
    chk1("lw_ack_valid", instr_valid, 1'b0);
    tick(); #1;
    chk32("lw_addr", imem_if.imem_addr, 32'h400);

    // Stall with ack at 0x20.
    jump = 1'b1; pc_j = 32'h20;
    tick();
    clr_redirect(); stall = 1'b1;
    #1;
    chk1("st_req0", imem_if.imem_req, 1'b0);
    chk1("st_valid0", instr_valid, 1'b0);
    tick(); #1;
    chk32("st_pc1", pc, 32'h20);
    chk1("st_valid1", instr_valid, 1'b0);
    tick();
    stall = 1'b0;
    #1;
    chk32("st_addr", imem_if.imem_addr, 32'h20);
    chk1("st_valid2", instr_valid, 1'b1);
    tick(); #1;
    chk32("st_once", imem_if.imem_addr, 32'h24);

    // Stall arriving while a request is outstanding keeps it asserted.
    imem_if.imem_ack = 1'b0;
    tick();
    stall = 1'b1;
    #1;
    chk1("so_req", imem_if.imem_req, 1'b1);
    chk32("so_addr", imem_if.imem_addr, 32'h24);
    tick();
    imem_if.imem_ack = 1'b1;
    #1;
    chk1("so_valid", instr_valid, 1'b0);
    tick(); #1;
    chk1("so_req_drop", imem_if.imem_req, 1'b0);
    chk32("so_pc", pc, 32'h24);
    tick();
    stall = 1'b0;
    #1;
    chk1("so_valid2", instr_valid, 1'b1);

    // jump_reg priority and misalignment (now at 0x28).
    tick();
    jump_reg = 1'b1; pc_r = 32'h103; jump = 1'b1; pc_j = 32'h500;
    #1;
    chk1("jr_adderr", addr_err, 1'b1);
    chk1("jr_valid", instr_valid, 1'b0);
    tick();
    clr_redirect();
    #1;
    chk32("jr_pc", pc, 32'h100);
    chk1("jr_adderr_off", addr_err, 1'b0);

    // Wrap.
    jump = 1'b1; pc_j = 32'hFFFF_FFFC;
    tick();
    clr_redirect();
    #1;
    chk32("wr_pc", pc, 32'hFFFF_FFFC);
    chk32("wr_plus4", pc_plus4, 32'h0);
    chk1("wr_valid", instr_valid, 1'b1);
    tick(); #1;
    chk32("wr_pc0", pc, 32'h0);
    chk1("wr_noerr", addr_err, 1'b0);

    // Reset during DRAIN.
    imem_if.imem_ack = 1'b0; jump = 1'b1; pc_j = 32'h600;
    tick();
    clr_redirect();
    #1;
    chk32("rd_pc_tgt", pc, 32'h600);
    chk1("rd_req", imem_if.imem_req, 1'b1);
    rst = 1'b1; imem_if.imem_ack = 1'b1;
    #1;
    chk32("rd_pc_reset", pc, 32'h0);
    chk1("rd_req_off", imem_if.imem_req, 1'b0);
    chk1("rd_valid", instr_valid, 1'b0);
    tick(); #1;
    chk1("rd_valid_edge", instr_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rd_boot_req", imem_if.imem_req, 1'b0);
    tick(); #1;
    chk32("rd_restart", imem_if.imem_addr, 32'h0);
    chk1("rd_restart_v", instr_valid, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
